// File: rtl/encoder_4to2_serial.sv
// Multi-hot 4-line request capture, serialised into one priority-encoded 2-bit code per accepted handshake.
// Latency: in captured at edge N+1, code out at N+2; out/out_valid hold while out_ready=0, throughput one code/cycle.
module encoder_4to2_serial #(
    parameter int HIGH_FIRST = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       in,
    output logic [1:0]       out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       pending,
    output logic             overflow,
    output logic [CNT_W-1:0] count
);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         out_q, out_d;
    logic [3:0]         pending_q, pending_d;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [1:0]         sel;
    logic               pend_any;
    logic               load;
    logic [3:0]         load_mask;
    logic [3:0]         in_eff;

    // Selection looks only at the registered pending set, never at same-cycle in.
    always_comb begin
        sel      = 2'd0;
        pend_any = |pending_q;
        if (HIGH_FIRST != 0) begin
            for (int i = 0; i < 4; i++) begin
                if (pending_q[i]) sel = 2'(i);
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (pending_q[i]) sel = 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_any) begin
                    load    = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (out_ready) begin
                    if (pend_any) load = 1'b1;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        load_mask  = load ? (4'b0001 << sel) : 4'b0000;
        in_eff     = en ? in : 4'b0000;
        // A bit cleared by this cycle's load may be re-requested without counting as a loss.
        pending_d  = (pending_q & ~load_mask) | in_eff;
        overflow_d = |(in_eff & pending_q & ~load_mask);
        out_d      = load ? sel : out_q;
        count_d    = (state_q == VALID && out_ready) ? count_q + CNT_W'(1) : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            out_q      <= 2'b00;
            pending_q  <= 4'b0000;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
        end
    end

    assign out       = out_q;
    assign out_valid = (state_q == VALID);
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign count     = count_q;

endmodule

// File: tb/tb_encoder_4to2_serial.sv
// Two instances (high-first/CNT_W=8 and low-first/CNT_W=2) share stimulus and are checked against a request-set model.
module tb_encoder_4to2_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] in;
    logic       out_ready;

    logic [1:0] out0, out1;
    logic       out_valid0, out_valid1;
    logic [3:0] pending0, pending1;
    logic       overflow0, overflow1;
    logic [7:0] count0;
    logic [1:0] count1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: index 0 = high-first DUT, 1 = low-first DUT.
    logic [3:0] m_pend [2];
    logic       m_vld  [2];
    logic [1:0] m_out  [2];
    logic       m_ovf  [2];
    int         m_cnt  [2];

    always #5 clk = ~clk;

    encoder_4to2_serial #(.HIGH_FIRST(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in),
        .out(out0), .out_valid(out_valid0), .out_ready(out_ready),
        .pending(pending0), .overflow(overflow0), .count(count0)
    );

    encoder_4to2_serial #(.HIGH_FIRST(0), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in),
        .out(out1), .out_valid(out_valid1), .out_ready(out_ready),
        .pending(pending1), .overflow(overflow1), .count(count1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int p, input logic [3:0] set);
        if (p == 0) begin
            for (int i = 3; i >= 0; i--) if (set[i]) return i;
        end else begin
            for (int i = 0; i < 4; i++) if (set[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_pend[p] = 4'b0000;
            m_vld[p]  = 1'b0;
            m_out[p]  = 2'b00;
            m_ovf[p]  = 1'b0;
            m_cnt[p]  = 0;
        end
    endtask

    // One clock edge of the request set: hand out one code if the consumer slot is free, then merge new requests.
    task automatic model_step(input logic s_en, input logic [3:0] s_in, input logic s_rdy);
        logic [3:0] taken;
        logic [3:0] newreq;
        int         idx;
        for (int p = 0; p < 2; p++) begin
            taken  = 4'b0000;
            newreq = s_en ? s_in : 4'b0000;
            if (m_vld[p] && s_rdy) m_cnt[p] = m_cnt[p] + 1;
            if ((!m_vld[p] || s_rdy) && m_pend[p] != 4'b0000) begin
                idx       = pick(p, m_pend[p]);
                m_out[p]  = 2'(idx);
                taken[idx] = 1'b1;
                m_vld[p]  = 1'b1;
            end else if (m_vld[p] && s_rdy) begin
                m_vld[p]  = 1'b0;
            end
            m_ovf[p]  = (newreq & m_pend[p] & ~taken) != 4'b0000;
            m_pend[p] = (m_pend[p] & ~taken) | newreq;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out0"},  32'(out0),       32'(m_out[0]));
        check({tag, ".vld0"},  32'(out_valid0), 32'(m_vld[0]));
        check({tag, ".pend0"}, 32'(pending0),   32'(m_pend[0]));
        check({tag, ".ovf0"},  32'(overflow0),  32'(m_ovf[0]));
        check({tag, ".cnt0"},  32'(count0),     32'(m_cnt[0] % 256));
        check({tag, ".out1"},  32'(out1),       32'(m_out[1]));
        check({tag, ".vld1"},  32'(out_valid1), 32'(m_vld[1]));
        check({tag, ".pend1"}, 32'(pending1),   32'(m_pend[1]));
        check({tag, ".ovf1"},  32'(overflow1),  32'(m_ovf[1]));
        check({tag, ".cnt1"},  32'(count1),     32'(m_cnt[1] % 4));
    endtask

    task automatic tick(input string tag);
        logic       s_en;
        logic [3:0] s_in;
        logic       s_rdy;
        s_en  = en;
        s_in  = in;
        s_rdy = out_ready;
        @(posedge clk);
        #1;
        model_step(s_en, s_in, s_rdy);
        check_model(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".out0"}, 32'(out0), 32'h0);
        check({tag, ".vld0"}, 32'(out_valid0), 32'h0);
        check({tag, ".pend0"}, 32'(pending0), 32'h0);
        check({tag, ".ovf0"}, 32'(overflow0), 32'h0);
        check({tag, ".cnt0"}, 32'(count0), 32'h0);
        check({tag, ".vld1"}, 32'(out_valid1), 32'h0);
        check({tag, ".pend1"}, 32'(pending1), 32'h0);
        check({tag, ".cnt1"}, 32'(count1), 32'h0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 check_zero("reset");
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; in = 4'b0000; out_ready = 1'b0;
        model_reset();
        #3 check_zero("por");
        @(posedge clk); #1;
        check_zero("por_hold");
        rst_n = 1'b1;

        // Single request: code 10 two edges after in is presented.
        en = 1'b1; in = 4'b0100; out_ready = 1'b1;
        tick("single_cap");
        check("single_cap.pend", 32'(pending0), 32'h4);
        in = 4'b0000;
        tick("single_load");
        check("single_load.vld", 32'(out_valid0), 32'h1);
        check("single_load.out", 32'(out0), 32'h2);
        tick("single_done");
        check("single_done.vld", 32'(out_valid0), 32'h0);
        check("single_done.cnt", 32'(count0), 32'h1);

        // Priority serialisation of 1011.
        in = 4'b1011;
        tick("prio_cap");
        in = 4'b0000;
        tick("prio_11");
        check("prio_11.out", 32'(out0), 32'h3);
        check("prio_11.pend", 32'(pending0), 32'hB ^ 32'h8);
        tick("prio_01");
        check("prio_01.out", 32'(out0), 32'h1);
        check("prio_01.pend", 32'(pending0), 32'h1);
        check("prio_01.out_lowfirst", 32'(out1), 32'h1);
        tick("prio_00");
        check("prio_00.out", 32'(out0), 32'h0);
        check("prio_00.pend", 32'(pending0), 32'h0);
        check("prio_00.out_lowfirst", 32'(out1), 32'h3);
        tick("prio_done");
        check("prio_done.cnt", 32'(count0), 32'h4);

        // Backpressure: code held for five stalled cycles.
        out_ready = 1'b0; in = 4'b1000;
        tick("bp_cap");
        in = 4'b0000;
        tick("bp_load");
        for (int i = 0; i < 5; i++) begin
            tick("bp_stall");
            check("bp_stall.out", 32'(out0), 32'h3);
            check("bp_stall.vld", 32'(out_valid0), 32'h1);
        end
        out_ready = 1'b1;
        tick("bp_accept");
        check("bp_accept.cnt", 32'(count0), 32'h5);
        check("bp_accept.vld", 32'(out_valid0), 32'h0);

        // Duplicate request while stalled, then re-request on the reload edge.
        out_ready = 1'b0; in = 4'b1000;
        tick("ovf_cap");
        in = 4'b0000;
        tick("ovf_load");
        in = 4'b0001;
        tick("ovf_first");
        check("ovf_first.ovf", 32'(overflow0), 32'h0);
        tick("ovf_dup");
        check("ovf_dup.ovf", 32'(overflow0), 32'h1);
        check("ovf_dup.pend", 32'(pending0), 32'h1);
        in = 4'b0000;
        tick("ovf_pulse_end");
        check("ovf_pulse_end.ovf", 32'(overflow0), 32'h0);
        out_ready = 1'b1; in = 4'b0001;
        tick("reload");
        check("reload.out", 32'(out0), 32'h0);
        check("reload.pend", 32'(pending0), 32'h1);
        check("reload.ovf", 32'(overflow0), 32'h0);
        in = 4'b0000;
        tick("reload_2");
        tick("reload_3");

        // en=0 ignores requests.
        en = 1'b0; in = 4'b1111;
        tick("en_off_1");
        tick("en_off_2");
        check("en_off.pend", 32'(pending0), 32'h0);
        en = 1'b1; in = 4'b0000;

        // Counter wrap on the 2-bit instance: five accepts from reset.
        do_reset();
        out_ready = 1'b1; in = 4'b1111;
        tick("wrap_cap");
        in = 4'b0000;
        for (int i = 0; i < 3; i++) tick("wrap_drain");
        in = 4'b0001;
        tick("wrap_last_cap");
        in = 4'b0000;
        for (int i = 0; i < 4; i++) tick("wrap_tail");
        check("wrap.cnt1", 32'(count1), 32'h1);
        check("wrap.cnt0", 32'(count0), 32'h5);

        // Asynchronous reset while a code is valid and 0110 is pending.
        out_ready = 1'b0; in = 4'b1000;
        tick("ar_cap");
        in = 4'b0110;
        tick("ar_load");
        in = 4'b0000;
        check("ar_pre.vld", 32'(out_valid0), 32'h1);
        check("ar_pre.pend", 32'(pending0), 32'h6);
        do_reset();
        tick("ar_resume");

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 7) != 0);
            in        = 4'($urandom_range(0, 15)) & ((($urandom_range(0, 2)) == 0) ? 4'hF : 4'h0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
